// File: rtl/receptor_i2c_pkg.sv
// ----------------------------------------------------------------------------
// receptor_i2c_pkg : shared state encoding and bus constants for the I2C target
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package receptor_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_BYTE   = 3'd3,
        WR_ACK    = 3'd4,
        RD_BYTE   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;
    localparam logic       RELEASED          = 1'b1;

endpackage

`default_nettype wire

// File: rtl/receptor_i2c_sync.sv
// ----------------------------------------------------------------------------
// receptor_i2c_sync : SCL/SDA synchroniser with SCL edge and START/STOP detect
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module receptor_i2c_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_async,
    input  logic sda_async,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl;

    // Flops reset to 1 so an idle (pulled-up) bus shows no edges after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_async};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_async};
            scl_prev <= scl_pipe[SYNC_STAGES-1];
            sda_prev <= sda_pipe[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_pipe[SYNC_STAGES-1];
    assign sda       = sda_pipe[SYNC_STAGES-1];
    assign scl_rise  =  scl & ~scl_prev;
    assign scl_fall  = ~scl &  scl_prev;
    assign start_det =  scl &  scl_prev &  sda_prev & ~sda;
    assign stop_det  =  scl &  scl_prev & ~sda_prev &  sda;

endmodule

`default_nettype wire

// File: rtl/receptor_i2c_multibyte.sv
// ----------------------------------------------------------------------------
// receptor_i2c_multibyte : I2C target moving NUM_BYTES-byte write/read payloads
// Optional macro RECEPTOR_GENERAL_CALL_EN also accepts general-call writes.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module receptor_i2c_multibyte
    import receptor_i2c_pkg::*;
#(
    parameter int NUM_BYTES   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_receptor,
    input  logic                   rst_receptor,
    input  logic [6:0]             I2C_ADDR_receptor,
    input  logic                   SCL,
    input  logic                   SDA_OUT,
    input  logic                   SDA_OE,
    input  logic [8*NUM_BYTES-1:0] RD_DATA_receptor,
    output logic                   SDA_IN,
    output logic [8*NUM_BYTES-1:0] WR_DATA_receptor,
    output logic                   WR_VALID,
    output logic                   BUSY
);

    localparam int         W        = 8 * NUM_BYTES;
    localparam logic [3:0] NB_COUNT = 4'(NUM_BYTES);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    receptor_i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk_receptor),
        .rst_n     (rst_receptor),
        .scl_async (SCL),
        .sda_async (SDA_OE ? SDA_OUT : RELEASED),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t         state, state_nxt;
    logic [3:0]     bit_cnt, bit_cnt_nxt;
    logic [3:0]     byte_idx, byte_idx_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic           sda_drv, sda_nxt;
    logic           busy_q, busy_nxt;
    logic [W-1:0]   shadow, shadow_nxt;
    logic [W-1:0]   staging, staging_nxt;
    logic [W-1:0]   wr_data, wr_data_nxt;
    logic           wr_valid_q, wr_valid_nxt;
    logic           addr_match;

    always_comb begin
        addr_match = (shreg[7:1] == I2C_ADDR_receptor);
`ifdef RECEPTOR_GENERAL_CALL_EN
        if (shreg[7:1] == GENERAL_CALL_ADDR && !shreg[0]) addr_match = 1'b1;
`endif
    end

    always_ff @(posedge clk_receptor or negedge rst_receptor) begin
        if (!rst_receptor) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            sda_drv    <= RELEASED;
            busy_q     <= 1'b0;
            shadow     <= '0;
            staging    <= '0;
            wr_data    <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_idx   <= byte_idx_nxt;
            shreg      <= shreg_nxt;
            sda_drv    <= sda_nxt;
            busy_q     <= busy_nxt;
            shadow     <= shadow_nxt;
            staging    <= staging_nxt;
            wr_data    <= wr_data_nxt;
            wr_valid_q <= wr_valid_nxt;
        end
    end

    // The shadow shifts left filling with 1s, so reads past NUM_BYTES send 0xFF.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        byte_idx_nxt = byte_idx;
        shreg_nxt    = shreg;
        sda_nxt      = sda_drv;
        busy_nxt     = busy_q;
        shadow_nxt   = shadow;
        staging_nxt  = staging;
        wr_data_nxt  = wr_data;
        wr_valid_nxt = 1'b0;
        if (start_det) begin
            state_nxt    = ADDR;
            bit_cnt_nxt  = '0;
            byte_idx_nxt = '0;
            sda_nxt      = RELEASED;
            busy_nxt     = 1'b0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_nxt     = RELEASED;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR, WR_BYTE: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], sda};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = '0;
                        if (state == ADDR) begin
                            if (addr_match) begin
                                state_nxt = ADDR_ACK;
                                sda_nxt   = 1'b0;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = WAIT_STOP;
                            end
                        end else begin
                            state_nxt = WR_ACK;
                            if (byte_idx < NB_COUNT) begin
                                sda_nxt      = 1'b0;
                                staging_nxt  = W'({staging, shreg});
                                byte_idx_nxt = byte_idx + 4'd1;
                                if (byte_idx == NB_COUNT - 4'd1) begin
                                    wr_data_nxt  = W'({staging, shreg});
                                    wr_valid_nxt = 1'b1;
                                end
                            end else begin
                                byte_idx_nxt = NB_COUNT + 4'd1;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        byte_idx_nxt = '0;
                        if (shreg[0]) begin
                            state_nxt   = RD_BYTE;
                            sda_nxt     = RD_DATA_receptor[W-1];
                            shadow_nxt  = {RD_DATA_receptor[W-2:0], 1'b1};
                            bit_cnt_nxt = 4'd1;
                        end else begin
                            state_nxt   = WR_BYTE;
                            sda_nxt     = RELEASED;
                            bit_cnt_nxt = '0;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt   = RELEASED;
                        state_nxt = (byte_idx > NB_COUNT) ? WAIT_STOP : WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt   = RD_ACK;
                            sda_nxt     = RELEASED;
                            bit_cnt_nxt = '0;
                        end else begin
                            sda_nxt     = shadow[W-1];
                            shadow_nxt  = {shadow[W-2:0], 1'b1};
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        shreg_nxt = {shreg[6:0], sda};
                    end else if (scl_fall) begin
                        if (!shreg[0]) begin
                            state_nxt   = RD_BYTE;
                            sda_nxt     = shadow[W-1];
                            shadow_nxt  = {shadow[W-2:0], 1'b1};
                            bit_cnt_nxt = 4'd1;
                        end else begin
                            state_nxt = WAIT_STOP;
                            sda_nxt   = RELEASED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDA_IN           = sda_drv;
    assign WR_DATA_receptor = wr_data;
    assign WR_VALID         = wr_valid_q;
    assign BUSY             = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_receptor_i2c_multibyte.sv
// ----------------------------------------------------------------------------
// tb_receptor_i2c_multibyte : bus-level generator with scoreboarded target output
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_receptor_i2c_multibyte;

    localparam int NUM_BYTES = 2;
    localparam int W         = 8 * NUM_BYTES;
    localparam int Q         = 100;

    logic         clk_receptor = 1'b0;
    logic         rst_receptor = 1'b0;
    logic [6:0]   I2C_ADDR_receptor = 7'h3D;
    logic         SCL = 1'b1;
    logic         SDA_OUT = 1'b1;
    logic         SDA_OE = 1'b0;
    logic [W-1:0] RD_DATA_receptor = '0;
    logic         SDA_IN;
    logic [W-1:0] WR_DATA_receptor;
    logic         WR_VALID;
    logic         BUSY;

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [7:0] id; logic val; } bit_exp_t;
    bit_exp_t     exp_bits[$];
    logic [W-1:0] exp_wr[$];
    logic [7:0]   tag = '0;

    receptor_i2c_multibyte #(.NUM_BYTES(NUM_BYTES), .SYNC_STAGES(2)) dut (
        .clk_receptor      (clk_receptor),
        .rst_receptor      (rst_receptor),
        .I2C_ADDR_receptor (I2C_ADDR_receptor),
        .SCL               (SCL),
        .SDA_OUT           (SDA_OUT),
        .SDA_OE            (SDA_OE),
        .RD_DATA_receptor  (RD_DATA_receptor),
        .SDA_IN            (SDA_IN),
        .WR_DATA_receptor  (WR_DATA_receptor),
        .WR_VALID          (WR_VALID),
        .BUSY              (BUSY)
    );

    always #5 clk_receptor = ~clk_receptor;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Whenever the generator has released SDA, the target owns the bit slot.
    initial begin : mon_sda
        bit_exp_t e;
        forever begin
            @(posedge SCL);
            #1;
            if (rst_receptor && !SDA_OE) begin
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_slot: got %b, required no target slot", SDA_IN);
                end else begin
                    e = exp_bits.pop_front();
                    check($sformatf("sda_slot_%0d", e.id), {31'd0, SDA_IN}, {31'd0, e.val});
                end
            end
        end
    end

    initial begin : mon_wr
        logic [W-1:0] e;
        forever begin
            @(negedge clk_receptor);
            if (WR_VALID) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_valid: got data %h, required no pulse", WR_DATA_receptor);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_data_on_valid", 32'(WR_DATA_receptor), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: got no end of stimulus, required finish within 500us");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    task automatic expect_bit(input logic v);
        bit_exp_t e;
        e.id  = tag;
        e.val = v;
        exp_bits.push_back(e);
        tag++;
    endtask

    task automatic drive_bit(input logic b);
        SDA_OE = 1'b1; SDA_OUT = b; #(Q);
        SCL = 1'b1; #(2*Q);
        SCL = 1'b0; #(Q);
    endtask

    task automatic release_bit();
        SDA_OE = 1'b0; #(Q);
        SCL = 1'b1; #(2*Q);
        SCL = 1'b0; #(Q);
    endtask

    task automatic i2c_start();
        SDA_OE = 1'b1; SDA_OUT = 1'b1; #(Q);
        SCL = 1'b1; #(Q);
        SDA_OUT = 1'b0; #(Q);
        SCL = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        SDA_OE = 1'b1; SDA_OUT = 1'b0; #(Q);
        SCL = 1'b1; #(Q);
        SDA_OUT = 1'b1; #(Q);
        SDA_OE = 1'b0; #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp);
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
        expect_bit(ack_exp);
        release_bit();
    endtask

    task automatic recv_byte(input logic [7:0] exp_byte, input logic master_ack);
        for (int i = 7; i >= 0; i--) begin
            expect_bit(exp_byte[i]);
            release_bit();
        end
        drive_bit(master_ack ? 1'b0 : 1'b1);
    endtask

    initial begin : stim
        RD_DATA_receptor = 16'hC3F0;
        repeat (3) @(posedge clk_receptor);
        #1;
        check("reset_sda_in", {31'd0, SDA_IN}, 32'd1);
        check("reset_wr_data", 32'(WR_DATA_receptor), 32'd0);
        check("reset_wr_valid", {31'd0, WR_VALID}, 32'd0);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        @(negedge clk_receptor) rst_receptor = 1'b1;
        #(4*Q);

        // Write 0xA55A to 7'h3D
        i2c_start();
        send_byte(8'h7A, 1'b0);
        check("busy_after_addr_ack", {31'd0, BUSY}, 32'd1);
        send_byte(8'hA5, 1'b0);
        exp_wr.push_back(16'hA55A);
        send_byte(8'h5A, 1'b0);
        i2c_stop();
        check("busy_after_stop", {31'd0, BUSY}, 32'd0);
        check("sda_after_stop", {31'd0, SDA_IN}, 32'd1);
        check("wr_data_write1", 32'(WR_DATA_receptor), 32'h0000A55A);

        // Read 0xC3F0; input changed after address must not matter
        i2c_start();
        send_byte(8'h7B, 1'b0);
        RD_DATA_receptor = 16'h0000;
        recv_byte(8'hC3, 1'b1);
        recv_byte(8'hF0, 1'b0);
        #(Q);
        check("sda_released_after_nack", {31'd0, SDA_IN}, 32'd1);
        i2c_stop();

        // Read beyond payload yields 0xFF
        RD_DATA_receptor = 16'h1E96;
        i2c_start();
        send_byte(8'h7B, 1'b0);
        recv_byte(8'h1E, 1'b1);
        recv_byte(8'h96, 1'b1);
        recv_byte(8'hFF, 1'b0);
        i2c_stop();

        // Address mismatch
        i2c_start();
        send_byte(8'h80, 1'b1);
        check("busy_mismatch", {31'd0, BUSY}, 32'd0);
        send_byte(8'hA5, 1'b1);
        i2c_stop();
        check("wr_data_after_mismatch", 32'(WR_DATA_receptor), 32'h0000A55A);

        // Partial write then repeated-start read
        RD_DATA_receptor = 16'hC3F0;
        i2c_start();
        send_byte(8'h7A, 1'b0);
        send_byte(8'h11, 1'b0);
        i2c_start();
        send_byte(8'h7B, 1'b0);
        recv_byte(8'hC3, 1'b1);
        recv_byte(8'hF0, 1'b0);
        i2c_stop();
        check("wr_data_after_rep_start", 32'(WR_DATA_receptor), 32'h0000A55A);

        // Reset during the ACK of the first data byte
        i2c_start();
        send_byte(8'h7A, 1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(1'(8'hA5 >> i));
        SDA_OE = 1'b0;
        #(Q);
        check("ack_before_reset", {31'd0, SDA_IN}, 32'd0);
        @(negedge clk_receptor) rst_receptor = 1'b0;
        #1;
        check("sda_in_reset", {31'd0, SDA_IN}, 32'd1);
        check("wr_data_reset", 32'(WR_DATA_receptor), 32'd0);
        check("busy_reset", {31'd0, BUSY}, 32'd0);
        SDA_OE = 1'b1; SDA_OUT = 1'b1; #(Q);
        SCL = 1'b1; #(2*Q);
        SCL = 1'b0; #(Q);
        @(negedge clk_receptor) rst_receptor = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        i2c_stop();

        // Full write after reset, plus an extra byte that must be NACKed
        i2c_start();
        send_byte(8'h7A, 1'b0);
        send_byte(8'hBE, 1'b0);
        exp_wr.push_back(16'hBEEF);
        send_byte(8'hEF, 1'b0);
        send_byte(8'h55, 1'b1);
        i2c_stop();
        check("wr_data_after_reset_write", 32'(WR_DATA_receptor), 32'h0000BEEF);

        // General call
        i2c_start();
`ifdef RECEPTOR_GENERAL_CALL_EN
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b0);
        exp_wr.push_back(16'h1234);
        send_byte(8'h34, 1'b0);
        i2c_stop();
        check("wr_data_general_call", 32'(WR_DATA_receptor), 32'h00001234);
`else
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        i2c_stop();
        check("wr_data_general_call", 32'(WR_DATA_receptor), 32'h0000BEEF);
`endif

        #(4*Q);
        check("pending_bit_expectations", 32'(exp_bits.size()), 32'd0);
        check("pending_wr_expectations", 32'(exp_wr.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
